// File: rtl/alu_divider_if.sv
// Handshake and operand/result bundle for the multi-cycle EX-stage divider.
interface alu_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             V;

  // The pipeline/hazard side issues requests and consumes results.
  modport master (
    output start, signed_op, A, B,
    input  Q, R, busy, done, div_zero, V
  );

  // The divider accepts requests and produces results.
  modport slave (
    input  start, signed_op, A, B,
    output Q, R, busy, done, div_zero, V
  );
endinterface

// File: rtl/alu_divider.sv
// Restoring divider, one subtract-and-shift per clock. Signed operands are
// divided as magnitudes and the signs are fixed up on the last iteration.
// Divide-by-zero and 0x8000/-1 saturate and finish in a single cycle.
module alu_divider #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  alu_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q, neg_rem_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic             dz_q, v_q;

  logic             accept, b_zero, ovf, a_neg, b_neg, last;
  logic [WIDTH-1:0] a_mag, b_mag, rem_n, quo_n;
  logic [WIDTH:0]   shifted, trial;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  // Request decode: a start is only honoured outside CALC.
  always_comb begin
    accept = bus.start && (state_q != CALC);
    b_zero = (bus.B == '0);
    ovf    = bus.signed_op && (bus.A == MINV) && (bus.B == ALL1);
    a_neg  = bus.signed_op && bus.A[WIDTH-1];
    b_neg  = bus.signed_op && bus.B[WIDTH-1];
    a_mag  = a_neg ? negate(bus.A) : bus.A;
    b_mag  = b_neg ? negate(bus.B) : bus.B;
  end

  // One restoring step: shift {rem,quo} left, keep the trial difference if non-negative.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    rem_n   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_n   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fast paths jump straight to DONE, DONE re-accepts a start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) state_d = (b_zero || ovf) ? DONE : CALC;
        else           state_d = IDLE;
      end
      CALC:    if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
      v_q       <= 1'b0;
    end else if (accept) begin
      if (b_zero) begin
        q_q  <= bus.signed_op ? (bus.A[WIDTH-1] ? MINV : MAXP) : ALL1;
        r_q  <= bus.A;
        dz_q <= 1'b1;
        v_q  <= 1'b0;
      end else if (ovf) begin
        q_q  <= MAXP;
        r_q  <= '0;
        dz_q <= 1'b0;
        v_q  <= 1'b1;
      end else begin
        rem_q     <= '0;
        quo_q     <= a_mag;
        dvsr_q    <= b_mag;
        cnt_q     <= '0;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        dz_q      <= 1'b0;
        v_q       <= 1'b0;
      end
    end else if (state_q == CALC) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + CW'(1);
      // Visible results only change once the final step is known.
      if (last) begin
        q_q <= neg_quo_q ? negate(quo_n) : quo_n;
        r_q <= neg_rem_q ? negate(rem_n) : rem_n;
      end
    end
  end

  assign bus.Q        = q_q;
  assign bus.R        = r_q;
  assign bus.busy     = (state_q == CALC);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = dz_q;
  assign bus.V        = v_q;
endmodule

// File: tb/tb_alu_divider.sv
// Directed and random checks of alu_divider against an integer-arithmetic model.
module tb_alu_divider;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_divider_if #(.WIDTH(16)) bus();
  alu_divider #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int kcyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncation toward zero, saturating corner cases.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output logic v, output logic fast);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0; v = 1'b0; fast = 1'b0;
    if (b == 16'h0) begin
      dz = 1'b1; fast = 1'b1; r = a;
      q = s ? (sa < 0 ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
    end else if (s && sa == -32768 && sb == -1) begin
      v = 1'b1; fast = 1'b1; q = 16'h7FFF; r = 16'h0000;
    end else if (s) begin
      q = 16'(sa / sb);
      r = 16'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Drive a start for exactly one active edge; kcyc marks that edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
    bus.A = a; bus.B = b; bus.signed_op = s; bus.start = 1'b1;
    @(posedge clk);
    #1;
    kcyc = cyc;
    bus.start = 1'b0;
  endtask

  // Wait for done (bounded), then check latency, busy length and results.
  task automatic wait_done(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input int busy0);
    logic [15:0] eq, er;
    logic edz, ev, fast, got;
    int bc;
    model(a, b, s, eq, er, edz, ev, fast);
    bc  = busy0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
      else if (bus.busy) bc++;
    end
    chk({tag, "/done_seen"}, 32'(got), 32'd1);
    chk({tag, "/latency"}, 32'(cyc - kcyc), fast ? 32'd0 : 32'd16);
    chk({tag, "/busy_cycles"}, 32'(bc), fast ? 32'd0 : 32'd16);
    chk({tag, "/Q"}, 32'(bus.Q), 32'(eq));
    chk({tag, "/R"}, 32'(bus.R), 32'(er));
    chk({tag, "/div_zero"}, 32'(bus.div_zero), 32'(edz));
    chk({tag, "/V"}, 32'(bus.V), 32'(ev));
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] eq, er;
    logic edz, ev, fast;
    model(a, b, s, eq, er, edz, ev, fast);
    @(negedge clk);
    launch(a, b, s);
    wait_done(tag, a, b, s, 0);
    @(negedge clk);
    chk({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "/Q_hold"}, 32'(bus.Q), 32'(eq));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic rs;
    int bc;
    int sel;
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    chk("reset/Q", 32'(bus.Q), 32'd0);
    chk("reset/R", 32'(bus.R), 32'd0);
    chk("reset/busy", 32'(bus.busy), 32'd0);
    chk("reset/done", 32'(bus.done), 32'd0);
    chk("reset/div_zero", 32'(bus.div_zero), 32'd0);
    chk("reset/V", 32'(bus.V), 32'd0);
    rst = 1'b0;

    do_op("u100div7", 16'd100, 16'd7, 1'b0);
    do_op("s-7div2", 16'hFFF9, 16'h0002, 1'b1);
    do_op("s7div-2", 16'h0007, 16'hFFFE, 1'b1);
    do_op("u5div0", 16'd5, 16'd0, 1'b0);
    do_op("s-5div0", 16'hFFFB, 16'd0, 1'b1);
    do_op("s5div0", 16'h0005, 16'd0, 1'b1);
    do_op("s_ovf", 16'h8000, 16'hFFFF, 1'b1);
    do_op("u_8000_ffff", 16'h8000, 16'hFFFF, 1'b0);
    do_op("s_min_div1", 16'h8000, 16'h0001, 1'b1);

    // A second start while iterating must be ignored.
    @(negedge clk);
    launch(16'd1000, 16'd3, 1'b0);
    bc = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy) bc++;
    end
    bus.A = 16'd9; bus.B = 16'd2; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("midcalc_restart", 16'd1000, 16'd3, 1'b0, bc);

    // Back-to-back: start presented during the DONE cycle.
    @(negedge clk);
    launch(16'd5000, 16'd13, 1'b0);
    wait_done("b2b_first", 16'd5000, 16'd13, 1'b0, 0);
    launch(16'hD8F1, 16'h0011, 1'b1);
    wait_done("b2b_second", 16'hD8F1, 16'h0011, 1'b1, 0);

    // Reset mid-iteration discards the result immediately.
    @(negedge clk);
    launch(16'd40000, 16'd9, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst/busy", 32'(bus.busy), 32'd0);
    chk("midrst/done", 32'(bus.done), 32'd0);
    chk("midrst/Q", 32'(bus.Q), 32'd0);
    chk("midrst/R", 32'(bus.R), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("after_rst", 16'd40000, 16'd9, 1'b0);

    // Random operations, with zero divisors, overflow and small divisors mixed in.
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rs  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 16'h0;
      else if (sel == 1) begin ra = 16'h8000; rb = 16'hFFFF; end
      else if (sel == 2) rb = 16'($urandom_range(1, 20));
      do_op("random", ra, rb, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
